xor_share_ctrl: RTL and testbench

Arbitrated bit-serial XOR engine. It shares a single `Xor` gate instance among `N_REQ` requesters, each presenting a `WIDTH`-bit operand pair. The block grants one requester at a time in round-robin order, streams the operands LSB-first through the shared gate, and returns the assembled word with a one-cycle completion pulse. It sits between the project-01 gate library and the upper-level chips that need occasional wide XOR without replicating gates.

---
 rtl/xor_share_pkg.sv | 30 +++
 rtl/Xor.sv | 16 +
 rtl/rr_pick.sv | 42 ++++
 rtl/xor_share_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_xor_share_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_share_pkg.sv
// -----------------------------------------------------------------------------
// xor_share_pkg
// Shared definitions for the arbitrated bit-serial XOR engine.
//   state_t : controller state encoding (IDLE/LOAD/SHIFT/DONE)
//   clog2   : ceiling log2, usable in constant (parameter) expressions
// -----------------------------------------------------------------------------
package xor_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/Xor.sv
// -----------------------------------------------------------------------------
// Xor
// Two-input XOR cell of the gate library; one instance is time-shared by
// xor_share_ctrl.
//   a, b : gate inputs
//   out  : a ^ b
// -----------------------------------------------------------------------------
module Xor (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a ^ b;

endmodule

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches upward from last+1
// (mod N_REQ) and returns the first asserted requester.
//   req      : request vector
//   last     : index of the most recently served requester
//   pick     : one-hot pick (all zero when req is zero)
//   pick_idx : binary index of pick (zero when req is zero)
// -----------------------------------------------------------------------------
module rr_pick
  import xor_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic found_s;

  // Priority search: offset k = 1 is the highest-ranked slot after last.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found_s && req[j] && (((int'(last) + k) % N_REQ) == j)) begin
          pick[j]  = 1'b1;
          pick_idx = IDX_W'(j);
          found_s  = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/xor_share_ctrl.sv
// -----------------------------------------------------------------------------
// xor_share_ctrl
// Arbitrated bit-serial XOR engine. N_REQ requesters share one Xor cell; the
// granted requester's operands are captured, streamed LSB-first through the
// cell, and the assembled word is returned with a one-cycle done pulse.
// Occupancy per transaction is WIDTH+3 cycles (IDLE, LOAD, WIDTH x SHIFT, DONE).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level
//   a_in, b_in : operands, requester i at [i*WIDTH +: WIDTH]
//   grant      : one-hot, requester being served (LOAD..DONE)
//   busy       : high in LOAD, SHIFT, DONE
//   done       : one-cycle pulse, out/done_id valid
//   done_id    : requester index of the result on out
//   out        : a ^ b, held until the next done
//   parity     : XOR-reduction of out (only with XOR_SHARE_PARITY_EN)
//
// Build option: define XOR_SHARE_PARITY_EN to add the parity output.
// -----------------------------------------------------------------------------
module xor_share_ctrl
  import xor_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     done,
  output logic [clog2(N_REQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         out
`ifdef XOR_SHARE_PARITY_EN
  ,
  output logic                     parity
`endif
);

  localparam int IDX_W = clog2(N_REQ);
  // cnt only has to reach WIDTH-1; keep at least one bit for WIDTH == 1.
  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_r;
  state_t            state_s;
  logic [N_REQ-1:0]  grant_r;
  logic [N_REQ-1:0]  pick_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [IDX_W-1:0]  sel_r;
  logic [IDX_W-1:0]  last_r;
  logic [IDX_W-1:0]  done_id_r;
  logic [WIDTH-1:0]  a_sr_r;
  logic [WIDTH-1:0]  b_sr_r;
  logic [WIDTH-1:0]  acc_r;
  logic [WIDTH-1:0]  acc_next_s;
  logic [WIDTH-1:0]  out_r;
  logic [WIDTH-1:0]  a_sel_s;
  logic [WIDTH-1:0]  b_sel_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              xor_out_s;
  logic              cnt_last_s;
`ifdef XOR_SHARE_PARITY_EN
  logic              par_acc_r;
  logic              parity_r;
`endif

  assign grant      = grant_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign done_id    = done_id_r;
  assign out        = out_r;
  assign cnt_last_s = (cnt_r == CNT_LAST);
`ifdef XOR_SHARE_PARITY_EN
  assign parity     = parity_r;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last     (last_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s)
  );

  // The single shared gate always sees the LSBs of the operand shifters.
  Xor u_xor (
    .a   (a_sr_r[0]),
    .b   (b_sr_r[0]),
    .out (xor_out_s)
  );

  // Operand slice of the granted requester (sampled only in LOAD).
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_r == IDX_W'(i)) begin
        a_sel_s = a_in[i*WIDTH +: WIDTH];
        b_sel_s = b_in[i*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  // Accumulator with the current gate output written into bit cnt.
  always_comb begin
    acc_next_s = acc_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        acc_next_s[i] = xor_out_s;
      end else begin
        acc_next_s[i] = acc_r[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arbitration, serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      out_r     <= '0;
      sel_r     <= '0;
      last_r    <= IDX_W'(N_REQ - 1);
      a_sr_r    <= '0;
      b_sr_r    <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            sel_r   <= pick_idx_s;
            grant_r <= pick_s;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
          a_sr_r <= a_sel_s;
          b_sr_r <= b_sel_s;
          acc_r  <= '0;
          cnt_r  <= '0;
        end
        ST_SHIFT: begin
          a_sr_r <= a_sr_r >> 1'b1;
          b_sr_r <= b_sr_r >> 1'b1;
          acc_r  <= acc_next_s;
          cnt_r  <= cnt_r + 1'b1;
          // Final bit goes straight to out so the result is valid in DONE.
          if (cnt_last_s) begin
            out_r     <= acc_next_s;
            done_r    <= 1'b1;
            done_id_r <= sel_r;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          grant_r <= '0;
          busy_r  <= 1'b0;
          last_r  <= sel_r;
        end
        default: begin
          done_r  <= 1'b0;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XOR_SHARE_PARITY_EN
  // Serial parity of the result bits, published alongside out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc_r <= 1'b0;
      parity_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD:  par_acc_r <= 1'b0;
        ST_SHIFT: begin
          par_acc_r <= par_acc_r ^ xor_out_s;
          if (cnt_last_s) begin
            parity_r <= par_acc_r ^ xor_out_s;
          end
        end
        default:  par_acc_r <= par_acc_r;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_xor_share_ctrl.sv
module tb_xor_share_ctrl;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (N_REQ=4, WIDTH=16)
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] a_in = '0;
  logic [N_REQ*WIDTH-1:0] b_in = '0;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [1:0]             done_id;
  logic [WIDTH-1:0]       out;
`ifdef XOR_SHARE_PARITY_EN
  logic                   parity;
`endif

  // Narrow instance (N_REQ=2, WIDTH=1)
  logic [1:0] req1 = '0;
  logic [1:0] a1 = '0;
  logic [1:0] b1 = '0;
  logic [1:0] grant1;
  logic       busy1;
  logic       done1;
  logic [0:0] done_id1;
  logic [0:0] out1;
`ifdef XOR_SHARE_PARITY_EN
  logic       parity1;
`endif

  xor_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id), .out(out)
`ifdef XOR_SHARE_PARITY_EN
    , .parity(parity)
`endif
  );

  xor_share_ctrl #(.N_REQ(2), .WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .a_in(a1), .b_in(b1),
    .grant(grant1), .busy(busy1), .done(done1), .done_id(done_id1), .out(out1)
`ifdef XOR_SHARE_PARITY_EN
    , .parity(parity1)
`endif
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  exp_t sb1_q[$];
  int   done_times[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_times.push_back(cyc);
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("out", 32'(out), e.val);
        check_val("done_id", 32'(done_id), 32'(e.id));
`ifdef XOR_SHARE_PARITY_EN
        check_val("parity", 32'(parity), 32'(^e.val));
`endif
      end
    end
  end

  // Scoreboard monitor for the WIDTH=1 instance
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      exp_t e;
      if (sb1_q.size() == 0) begin
        check_val("w1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb1_q.pop_front();
        check_val("w1_out", 32'(out1), e.val);
        check_val("w1_done_id", 32'(done_id1), 32'(e.id));
      end
    end
  end

  task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[id*WIDTH +: WIDTH] = a;
    b_in[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction; called at a negedge with the DUT idle.
  // With corrupt set, req and the operands are changed during SHIFT.
  task automatic run_one(input logic [N_REQ-1:0] mask, input int id,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit corrupt);
    int n;
    logic [N_REQ-1:0] gexp;
    gexp = '0;
    gexp[id] = 1'b1;
    set_ops(id, a, b);
    sb_q.push_back('{id, 32'(a ^ b)});
    req = mask;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    check_val("grant", 32'(grant), 32'(gexp));
    check_val("busy", 32'(busy), 32'd1);
    if (!corrupt) req = '0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (corrupt && n == 4) begin
        req = '0;
        set_ops(id, ~a, b ^ 16'h5A5A);
      end
    end
    check_val("done_latency", 32'(n), 32'(WIDTH + 2));
    check_val("grant_in_done", 32'(grant), 32'(gexp));
    @(negedge clk);
    check_val("done_pulse_end", 32'(done), 32'd0);
    check_val("grant_drop", 32'(grant), 32'd0);
    check_val("busy_drop", 32'(busy), 32'd0);
    check_val("out_hold", 32'(out), 32'(a ^ b));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int guard;
    int ndone;
    logic [WIDTH-1:0] av[N_REQ];
    logic [WIDTH-1:0] bv[N_REQ];

    // Reset state
    #1;
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_done_id", 32'(done_id), 32'd0);
    check_val("rst_out", 32'(out), 32'd0);
`ifdef XOR_SHARE_PARITY_EN
    check_val("rst_parity", 32'(parity), 32'd0);
`endif
    do_reset();

    // Single request from requester 0
    run_one(4'b0001, 0, 16'hFFFF, 16'h0F0F, 1'b0);

    // Four requesters held continuously: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      av[i] = 16'($urandom);
      bv[i] = 16'($urandom);
      set_ops(i, av[i], bv[i]);
    end
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{i % N_REQ, 32'(av[i % N_REQ] ^ bv[i % N_REQ])});
    end
    done_times.delete();
    req   = 4'hF;
    ndone = 0;
    guard = 0;
    while (ndone < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (done === 1'b1) ndone++;
    end
    req = '0;
    check_val("rr_done_count", 32'(ndone), 32'd5);
    @(negedge clk);
    @(negedge clk);
    if (done_times.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        check_val("rr_interval", 32'(done_times[i] - done_times[i-1]), 32'(WIDTH + 3));
      end
    end else begin
      check_val("rr_done_times", 32'(done_times.size()), 32'd5);
    end

    // Requester 2 drops req and changes operands during SHIFT
    run_one(4'b0100, 2, 16'h1234, 16'h00FF, 1'b1);

    // Reset in SHIFT at cnt=5
    set_ops(0, 16'h1111, 16'h2222);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_grant", 32'(grant), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_out", 32'(out), 32'd0);
    check_val("abort_done_id", 32'(done_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    // Priority restarts at requester 0 (pointer was at 2 before reset)
    run_one(4'b1001, 0, 16'hC3C3, 16'h0FF0, 1'b0);

    // Edge operands
    run_one(4'b0010, 1, 16'hAAAA, 16'hAAAA, 1'b0);
    run_one(4'b1000, 3, 16'h0000, 16'h8001, 1'b0);

    // Random single requests
    for (int k = 0; k < 4; k++) begin
      int id;
      logic [N_REQ-1:0] m;
      id = int'($urandom_range(0, N_REQ - 1));
      m = '0;
      m[id] = 1'b1;
      run_one(m, id, 16'($urandom), 16'($urandom), 1'b0);
    end

    // WIDTH=1 truth table
    for (int v = 0; v < 4; v++) begin
      int id;
      logic [1:0] gexp;
      id = v % 2;
      gexp = '0;
      gexp[id] = 1'b1;
      a1 = '0;
      b1 = '0;
      a1[id] = v[0];
      b1[id] = v[1];
      sb1_q.push_back('{id, 32'(v[0] ^ v[1])});
      req1 = gexp;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      check_val("w1_grant", 32'(grant1), 32'(gexp));
      req1 = '0;
      while (done1 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_val("w1_latency", 32'(n), 32'd3);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    check_val("sb1_empty", 32'(sb1_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
